// File: rtl/cross_window_gen.sv
// Raster-scan cross-window builder: emits {up,right,down,left} around each interior
// centre pixel, one cycle after the pixel that completes the window is accepted.
module cross_window_gen #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int XW     = $clog2(WIDTH),
    parameter int YW     = $clog2(HEIGHT)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [7:0]    pixelIn,
    input  logic          pixelValid,
    input  logic          frameStart,
    output logic [31:0]   blockOut,
    output logic          blockValid,
    output logic [XW-1:0] centreX,
    output logic [YW-1:0] centreY,
    output logic          frameDone
);

    localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);
    localparam logic [XW-1:0] COL_MIN  = XW'(2);
    localparam logic [YW-1:0] ROW_MIN  = YW'(2);

    logic [XW-1:0] col;
    logic [YW-1:0] row;
    logic [XW-1:0] cur_col;
    logic [YW-1:0] cur_row;

    logic [7:0] lb1 [WIDTH];
    logic [7:0] lb2 [WIDTH];
    logic [7:0] rd_a;
    logic [7:0] rd_b;

    logic [7:0] m0;
    logic [7:0] m1;
    logic [7:0] up_q;
    logic [7:0] down_q;

    logic win_ok;
    logic last_pix;

    // frameStart forces the accompanying pixel to (0,0), also mid-frame
    assign cur_col  = frameStart ? '0 : col;
    assign cur_row  = frameStart ? '0 : row;

    assign rd_a     = lb1[cur_col];
    assign rd_b     = lb2[cur_col];

    assign win_ok   = (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
    assign last_pix = (cur_col == COL_LAST) && (cur_row == ROW_LAST);

    // Line buffers carry no reset; rows 0 and 1 never emit, so stale data stays hidden
    always_ff @(posedge clock) begin
        if (pixelValid) begin
            lb1[cur_col] <= pixelIn;
            lb2[cur_col] <= rd_a;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            col        <= '0;
            row        <= '0;
            m0         <= '0;
            m1         <= '0;
            up_q       <= '0;
            down_q     <= '0;
            blockOut   <= '0;
            blockValid <= 1'b0;
            centreX    <= '0;
            centreY    <= '0;
            frameDone  <= 1'b0;
        end else begin
            blockValid <= pixelValid && win_ok;
            frameDone  <= pixelValid && win_ok && last_pix;
            if (pixelValid) begin
                if (cur_col == COL_LAST) begin
                    col <= '0;
                    row <= (cur_row == ROW_LAST) ? '0 : cur_row + YW'(1);
                end else begin
                    col <= cur_col + XW'(1);
                    row <= cur_row;
                end
                m0     <= rd_a;
                m1     <= m0;
                up_q   <= rd_b;
                down_q <= pixelIn;
                if (win_ok) begin
                    blockOut <= {up_q, rd_a, down_q, m1};
                    centreX  <= cur_col - XW'(1);
                    centreY  <= cur_row - YW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_cross_window_gen.sv
// Directed bench for cross_window_gen on an 8x6 frame: window values, count,
// gaps, border suppression, mid-frame resync and asynchronous reset.
module tb_cross_window_gen;

    localparam int W  = 8;
    localparam int H  = 6;
    localparam int XW = 3;
    localparam int YW = 3;

    logic          clock = 1'b0;
    logic          reset;
    logic [7:0]    pixelIn;
    logic          pixelValid;
    logic          frameStart;
    logic [31:0]   blockOut;
    logic          blockValid;
    logic [XW-1:0] centreX;
    logic [YW-1:0] centreY;
    logic          frameDone;

    int total = 0;
    int bad   = 0;

    int          nwin;
    int          border_hits;
    logic [31:0] first_blk, last_blk;
    int          first_cx, first_cy, last_cx, last_cy;

    cross_window_gen #(.WIDTH(W), .HEIGHT(H)) dut (
        .clock      (clock),
        .reset      (reset),
        .pixelIn    (pixelIn),
        .pixelValid (pixelValid),
        .frameStart (frameStart),
        .blockOut   (blockOut),
        .blockValid (blockValid),
        .centreX    (centreX),
        .centreY    (centreY),
        .frameDone  (frameDone)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int x, input int y, input bit ff);
        return ff ? 8'hFF : 8'(16 * y + x);
    endfunction

    function automatic logic [31:0] win(input int x, input int y, input bit ff);
        return {pix(x - 1, y - 2, ff), pix(x, y - 1, ff), pix(x - 1, y, ff), pix(x - 2, y - 1, ff)};
    endfunction

    task automatic step(input logic v, input logic fs, input logic [7:0] p);
        pixelValid = v;
        frameStart = fs;
        pixelIn    = p;
        @(posedge clock);
        #1;
        if (blockValid && (centreX == 0 || centreX == XW'(W - 1) ||
                           centreY == 0 || centreY == YW'(H - 1)))
            border_hits++;
    endtask

    // Streams the first npix pixels of a frame, checking every output cycle
    task automatic run_frame(input bit gaps, input bit ff, input int npix);
        int idx = 0;
        int cyc = 0;
        int x, y;
        bit ev;
        nwin = 0;
        while (idx < npix) begin
            if (gaps && (cyc % 3 == 2)) begin
                step(1'b0, 1'b0, 8'h00);
                check("gap_bv", 32'(blockValid), 32'd0);
                check("gap_fd", 32'(frameDone), 32'd0);
            end else begin
                x  = idx % W;
                y  = idx / W;
                step(1'b1, idx == 0, pix(x, y, ff));
                ev = (x >= 2) && (y >= 2);
                check("bv", 32'(blockValid), 32'(ev));
                check("fd", 32'(frameDone), 32'(x == W - 1 && y == H - 1));
                if (ev) begin
                    check("blk", blockOut, win(x, y, ff));
                    check("cx", 32'(centreX), 32'(x - 1));
                    check("cy", 32'(centreY), 32'(y - 1));
                    if (nwin == 0) begin
                        first_blk = blockOut;
                        first_cx  = int'(centreX);
                        first_cy  = int'(centreY);
                    end
                    last_blk = blockOut;
                    last_cx  = int'(centreX);
                    last_cy  = int'(centreY);
                    nwin++;
                end
                idx++;
            end
            cyc++;
        end
    endtask

    task automatic check_frame_summary(input string tag);
        check({tag, "_nwin"}, 32'(nwin), 32'd24);
        check({tag, "_first_blk"}, first_blk, 32'h01122110);
        check({tag, "_first_cx"}, 32'(first_cx), 32'd1);
        check({tag, "_first_cy"}, 32'(first_cy), 32'd1);
        // up P(6,3)=54, right P(7,4)=71, down P(6,5)=86, left P(5,4)=69
        check({tag, "_last_blk"}, last_blk, 32'h36475645);
        check({tag, "_last_cx"}, 32'(last_cx), 32'd6);
        check({tag, "_last_cy"}, 32'(last_cy), 32'd4);
    endtask

    initial begin
        border_hits = 0;
        reset       = 1'b1;
        pixelValid  = 1'b0;
        frameStart  = 1'b0;
        pixelIn     = 8'h00;
        #2;
        check("rst_bv",  32'(blockValid), 32'd0);
        check("rst_fd",  32'(frameDone), 32'd0);
        check("rst_blk", blockOut, 32'd0);
        check("rst_cx",  32'(centreX), 32'd0);
        check("rst_cy",  32'(centreY), 32'd0);
        #11;
        reset = 1'b0;
        @(posedge clock);
        #1;

        // Contiguous frame
        run_frame(1'b0, 1'b0, W * H);
        check_frame_summary("t1");
        check("t4_border", 32'(border_hits), 32'd0);

        // Gap on every third cycle
        run_frame(1'b1, 1'b0, W * H);
        check_frame_summary("t3");

        // Resync: frameStart arrives where pixel (3,4) would have been
        run_frame(1'b0, 1'b0, 4 * W + 3);
        check("t5_pre_nwin", 32'(nwin), 32'd13);
        run_frame(1'b0, 1'b1, W * H);
        check("t5_nwin", 32'(nwin), 32'd24);
        check("t5_first_blk", first_blk, 32'hFFFFFFFF);
        check("t5_first_cx", 32'(first_cx), 32'd1);
        check("t5_first_cy", 32'(first_cy), 32'd1);

        // Asynchronous reset between clock edges, right after a valid window
        run_frame(1'b0, 1'b0, 20);
        check("t6_pre_bv", 32'(blockValid), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("t6_bv",  32'(blockValid), 32'd0);
        check("t6_fd",  32'(frameDone), 32'd0);
        check("t6_blk", blockOut, 32'd0);
        check("t6_cx",  32'(centreX), 32'd0);
        #3;
        reset = 1'b0;
        @(posedge clock);
        #1;
        run_frame(1'b0, 1'b0, W * H);
        check_frame_summary("t6");
        check("border_all", 32'(border_hits), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
